// File: rtl/i2s_dac_tx.sv
// I2S transmitter: buffers mono samples in a small FIFO, derives MCLK/BCLK/LRCK
// from the system clock and sends each sample on both slots, MSB first.
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned MCLK_LOG2  = 2,
    parameter int unsigned BCLK_LOG2  = 5
) (
    input  logic                  sys_clk_100,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  clr_flags,
    output logic                  i2s_mclk,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdout,
    output logic                  underrun,
    output logic                  overflow,
    output logic [FIFO_AW:0]      fifo_level
);

    localparam int unsigned CNT_W  = BCLK_LOG2 + 6;
    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned SLOT_W = 32;
    localparam int unsigned PAD_W  = SLOT_W - DATA_WIDTH;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    logic [CNT_W-1:0]      cnt;
    logic [5:0]            bit_idx;
    logic [4:0]            bit_sel;
    logic                  frame_load;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [FIFO_AW:0]      level_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] slot_src;
    logic [SLOT_W-1:0]     slot_word;
    logic [SLOT_W-1:0]     slot_word_nxt;

    assign bit_idx    = cnt[CNT_W-1:BCLK_LOG2];
    assign frame_load = (cnt == '0);
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);

    // FIFO handshake: pop only at frame start; a pop frees room for a same-cycle push
    always_comb begin
        pop       = frame_load && !fifo_empty;
        push      = s_valid && (!fifo_full || pop);
        drop      = s_valid && fifo_full && !pop;
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            level_nxt = fifo_level - (FIFO_AW + 1)'(1);
        end
        slot_src      = pop ? mem[rd_ptr] : hold;
        slot_word_nxt = SLOT_W'(slot_src) << PAD_W;
        // one-BCLK delay: bit b carries slot bit 31-((b-1) mod 32); b=0 gives the previous LSB
        bit_sel       = 5'(~(bit_idx - 6'd1));
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge sys_clk_100) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers, occupancy, status and sticky flags (set wins over clear)
    always_ff @(posedge sys_clk_100 or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b0;
            hold       <= '0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
                hold   <= mem[rd_ptr];
            end
            fifo_level <= level_nxt;
            s_ready    <= (level_nxt != FULL_LEVEL);
            if (frame_load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame counter, clock generation and serializer
    always_ff @(posedge sys_clk_100 or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            slot_word <= '0;
            i2s_mclk  <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdout <= 1'b0;
        end else begin
            cnt      <= cnt + CNT_W'(1);
            i2s_mclk <= cnt[MCLK_LOG2-1];
            i2s_bclk <= cnt[BCLK_LOG2-1];
            i2s_lrck <= bit_idx[5];
            if (cnt[BCLK_LOG2-1:0] == '0) begin
                i2s_sdout <= slot_word[bit_sel];
            end
            if (frame_load) begin
                slot_word <= slot_word_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a queue model predicts frame words and
// status; a negedge monitor reassembles serial frames and checks them.
module tb_i2s_dac_tx;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          clr_flags;
    logic          i2s_mclk;
    logic          i2s_bclk;
    logic          i2s_lrck;
    logic          i2s_sdout;
    logic          underrun;
    logic          overflow;
    logic [AW:0]   fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_dac_tx #(.DATA_WIDTH(DW), .FIFO_AW(AW), .MCLK_LOG2(2), .BCLK_LOG2(5)) dut (
        .sys_clk_100(clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .clr_flags  (clr_flags),
        .i2s_mclk   (i2s_mclk),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdout  (i2s_sdout),
        .underrun   (underrun),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample queue with capacity DEPTH, one word per frame
    logic [DW-1:0] m_q[$];
    logic [31:0]   exp_q[$];
    logic [DW-1:0] m_hold;
    bit            m_under;
    bit            m_over;
    bit            m_ready;
    int            mk;

    always @(posedge clk or negedge rst) begin
        bit uset;
        bit oset;
        if (!rst) begin
            m_q.delete();
            exp_q.delete();
            m_hold  = '0;
            m_under = 1'b0;
            m_over  = 1'b0;
            m_ready = 1'b0;
            mk      = 0;
        end else begin
            uset = 1'b0;
            oset = 1'b0;
            if (mk % FRAME == 0) begin
                if (m_q.size() > 0) m_hold = m_q.pop_front();
                else uset = 1'b1;
                exp_q.push_back({m_hold, 16'h0000});
            end
            if (s_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(s_data);
                else oset = 1'b1;
            end
            m_under = uset ? 1'b1 : (clr_flags ? 1'b0 : m_under);
            m_over  = oset ? 1'b1 : (clr_flags ? 1'b0 : m_over);
            m_ready = (m_q.size() != DEPTH);
            mk++;
        end
    end

    // Monitor: clocks per cycle, status per cycle, serial words per BCLK rise
    int          r;
    int          n;
    int          c;
    int          b;
    bit          prev_bclk;
    bit          prev_sd;
    logic [31:0] lw;
    logic [31:0] rw;

    always @(negedge clk) begin
        if (!rst) begin
            r = 0; prev_bclk = 1'b0; prev_sd = 1'b0; lw = '0; rw = '0;
        end else begin
            n = mk;
            if (n == 0) begin
                check("clk_outs_c0", {28'd0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdout}, 32'd0);
            end else begin
                c = (n - 1) % FRAME;
                check("mclk", 32'(i2s_mclk), 32'((c >> 1) & 1));
                check("bclk", 32'(i2s_bclk), 32'((c >> 4) & 1));
                check("lrck", 32'(i2s_lrck), 32'(c >= 1024));
            end
            check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            check("s_ready", 32'(s_ready), 32'(m_ready));
            check("underrun", 32'(underrun), 32'(m_under));
            check("overflow", 32'(overflow), 32'(m_over));
            if (i2s_sdout != prev_sd)
                check("sdout_on_bclk_fall", {30'd0, prev_bclk, i2s_bclk}, 32'd2);
            if (!prev_bclk && i2s_bclk) begin
                b = r % 64;
                if (b == 0) begin
                    if (r == 0) begin
                        check("first_bit0", 32'(i2s_sdout), 32'd0);
                    end else begin
                        rw = {rw[30:0], i2s_sdout};
                        if (exp_q.size() == 0) check("right_no_expect", rw, 32'hxxxx_xxxx);
                        else check("right_word", rw, exp_q.pop_front());
                    end
                end else if (b <= 32) begin
                    lw = {lw[30:0], i2s_sdout};
                    if (b == 32) begin
                        if (exp_q.size() == 0) check("left_no_expect", lw, 32'hxxxx_xxxx);
                        else check("left_word", lw, exp_q[0]);
                    end
                end else begin
                    rw = {rw[30:0], i2s_sdout};
                end
                r++;
            end
            prev_bclk = i2s_bclk;
            prev_sd   = i2s_sdout;
        end
    end

    // Stimulus helpers: the driver always sits at posedge+1
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (mk % FRAME == target) return;
            tick(1);
        end
        check("wait_cnt_timeout", 32'(mk % FRAME), 32'(target));
    endtask

    task automatic push(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; clr_flags = 1'b0; rst = 1'b0;
        tick(3);
        check("rst_outs", {25'd0, s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdout, underrun, overflow}, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // release: current cycle has cnt==0
        rst = 1'b1;
        tick(1);
        check("first_load_underrun", 32'(underrun), 32'd1);

        // single sample loaded at the second frame
        tick(99);
        push(16'hA5C3);
        check("single_level", 32'(fifo_level), 32'd1);
        wait_cnt(500);
        pulse_clr();
        tick(2);
        wait_cnt(1);
        check("single_popped", 32'(fifo_level), 32'd0);
        wait_cnt(500);
        pulse_clr();
        check("underrun_cleared", 32'(underrun), 32'd0);
        wait_cnt(1);
        check("underrun_reset", 32'(underrun), 32'd1);

        // overflow: five back-to-back pushes into an empty FIFO
        wait_cnt(100);
        for (int i = 1; i <= 5; i++) push(DW'(i));
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_ready", 32'(s_ready), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        repeat (5) begin tick(FRAME); end

        // full FIFO with a push coincident with the frame load
        wait_cnt(50);
        pulse_clr();
        wait_cnt(100);
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        wait_cnt(0);
        push(DW'($urandom));
        check("simul_level", 32'(fifo_level), 32'd4);
        check("simul_no_ovf", 32'(overflow), 32'd0);
        repeat (5) begin tick(FRAME); end

        // randomized traffic
        for (int i = 0; i < 10; i++) begin
            tick($urandom_range(50, 1500));
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(DW'($urandom));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        tick(FRAME);

        // reset in the middle of a frame (b = 10)
        push(16'h1234);
        wait_cnt(323);
        rst = 1'b0;
        #1;
        check("midrst_outs", {25'd0, s_ready, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdout, underrun, overflow}, 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("post_rst_underrun", 32'(underrun), 32'd1);
        tick(2 * FRAME + 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
